led_scan_driver: RTL and testbench
==================================

// Module: led_scan_driver
// PURPOSE
//  Time-multiplexed driver for a NUM_DIGITS common-select 7-segment bank. Each digit holds a
//  hex nibble plus a decimal point, decoded to segments. Digits are scanned one at a time, with
//  a blanking guard between slots to suppress ghosting. Data is double-buffered so updates
//  never tear mid-frame. Sits between board-level display logic and the LED/segment pins.
// PARAMETERS
//  NUM_DIGITS     8      digits scanned, 1..16
//  CLK_DIV        50000  i_clk cycles per digit slot; must be > BLANK_CYCLES
//  BLANK_CYCLES   500    cycles at slot start with all digits deselected; 0 = no guard
//  SEG_ACT_LOW    1      1: o_seg bit low = segment lit; 0: high = lit
//  DIG_ACT_LOW    1      1: o_dig_sel bit low = digit selected; 0: high = selected
// PORTS
//  i_clk        in   1             clock
//  i_rst_n      in   1             synchronous active-low reset
//  i_data       in   NUM_DIGITS*4  hex nibble per digit; digit k = i_data[4k+3:4k]
//  i_dp         in   NUM_DIGITS    decimal point per digit, 1 = lit
//  i_en_mask    in   NUM_DIGITS    1 = digit displayed; 0 = digit kept dark (slot time kept)
//  i_load       in   1             capture i_data/i_dp/i_en_mask into pending buffer
//  o_seg        out  8             {dp,g,f,e,d,c,b,a}, polarity per SEG_ACT_LOW
//  o_dig_sel    out  NUM_DIGITS    one-hot digit select, polarity per DIG_ACT_LOW
//  o_frame_done out  1             1-cycle pulse on last cycle of each full scan
// BEHAVIOUR
//  - Reset (i_rst_n=0 at rising i_clk): cnt=0, idx=0, pending and active buffers = 0 (data,
//    dp, mask), pending_valid=0; o_seg all off, o_dig_sel all deselected, o_frame_done=0.
//    Reset mid-scan aborts the slot immediately; the first cycle after release is cnt=0, idx=0.
//  - Counters: cnt counts 0..CLK_DIV-1, then wraps to 0 and idx increments; idx wraps
//    NUM_DIGITS-1 -> 0. Widths are $clog2 sized; no overflow beyond these ranges.
//  - Slot phases (state machine): BLANK while cnt < BLANK_CYCLES, DRIVE while cnt >= BLANK_CYCLES.
//    BLANK: o_dig_sel all deselected, o_seg all off. DRIVE: o_dig_sel selects idx only when
//    active_mask[idx]=1, else all deselected; o_seg = decode(active nibble idx, active dp idx).
//  - Outputs are registered and aligned with cnt/idx: they reflect the cnt/idx values held in
//    the same cycle, with no extra pipeline lag visible at the pins.
//  - Decode (active-high form, before polarity): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
//    8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71; bit7 = dp. SEG_ACT_LOW=1 inverts all 8 bits.
//  - Double buffer: i_load=1 copies inputs to pending and sets pending_valid. On the frame-end
//    cycle (idx=NUM_DIGITS-1, cnt=CLK_DIV-1), if pending_valid, then pending -> active and
//    pending_valid clears. The new data shows from the next frame's slot 0.
//  - i_load on the frame-end cycle: the inputs in that cycle go directly to active, bypassing
//    pending; pending_valid=0 afterwards. Repeated i_load within one frame: last one wins.
//  - o_frame_done=1 exactly on the frame-end cycle, once per NUM_DIGITS*CLK_DIV cycles.
//  - NUM_DIGITS=1: idx fixed at 0, and every slot end is a frame end.
//    BLANK_CYCLES=0: the DRIVE phase fills the whole slot.
// TESTING (NUM_DIGITS=4, CLK_DIV=8, BLANK_CYCLES=2, SEG_ACT_LOW=1, DIG_ACT_LOW=1)
//  1 Reset: hold i_rst_n=0 for 3 cycles -> o_seg=8'hFF, o_dig_sel=4'hF, o_frame_done=0;
//    after release, cnt=0 and idx=0 on the first cycle.
//  2 Load i_data=16'h3210, i_dp=0, i_en_mask=4'hF; wait for the frame boundary ->
//    slot0: cnt0-1 o_dig_sel=F, cnt2-7 o_dig_sel=E, o_seg=~3F (C0);
//    slot1: dig_sel=D, o_seg=F9; slot2: dig_sel=B, o_seg=A4; slot3: dig_sel=7, o_seg=B0.
//  3 Sweep all 16 nibbles x dp, one full frame each -> o_seg matches the decode table
//    (e.g. F with dp -> ~F1 = 8'h0E).
//  4 i_en_mask=4'b1010 -> slots 0 and 2 show dig_sel=F for all 8 cycles; slots 1 and 3 are
//    driven normally; o_frame_done still pulses every 32 cycles.
//  5 No tearing: during slot 1, load i_data=16'hFFFF -> slots 1-3 of this frame keep the old
//    values; the next slot 0 shows F. A load on the frame-end cycle takes effect in the next
//    slot 0 (bypass path).
//  6 Reset mid-operation: deassert i_rst_n at idx=2, cnt=5 -> next cycle outputs are all off
//    and the buffers read 0; after release, scanning restarts at slot 0 with all digits dark
//    (mask=0) until a new load.

Source files
------------

// File: rtl/led_scan_driver.sv
// led_scan_driver
//   Time-multiplexed driver for a bank of NUM_DIGITS common-select 7-segment
//   digits. Each digit shows a hex nibble plus a decimal point. Each digit slot
//   lasts CLK_DIV cycles. The first BLANK_CYCLES of a slot deselect every digit
//   to suppress ghosting. New data is staged in a pending buffer and moves to
//   the active buffer only at the end of a full scan, so a frame never tears.
//
// Ports
//   i_clk        clock
//   i_rst_n      synchronous active-low reset
//   i_data       hex nibble per digit, digit k = i_data[4k+3:4k]
//   i_dp         decimal point per digit, 1 = lit
//   i_en_mask    1 = digit displayed, 0 = digit kept dark (slot time kept)
//   i_load       capture i_data/i_dp/i_en_mask into the pending buffer
//   o_seg        {dp,g,f,e,d,c,b,a}, polarity set by SEG_ACT_LOW
//   o_dig_sel    one-hot digit select, polarity set by DIG_ACT_LOW
//   o_frame_done 1-cycle pulse on the last cycle of each full scan
module led_scan_driver #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned CLK_DIV      = 50000,
    parameter int unsigned BLANK_CYCLES = 500,
    parameter bit          SEG_ACT_LOW  = 1'b1,
    parameter bit          DIG_ACT_LOW  = 1'b1
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_DIGITS*4-1:0] i_data,
    input  logic [NUM_DIGITS-1:0]   i_dp,
    input  logic [NUM_DIGITS-1:0]   i_en_mask,
    input  logic                    i_load,
    output logic [7:0]              o_seg,
    output logic [NUM_DIGITS-1:0]   o_dig_sel,
    output logic                    o_frame_done
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0]      CNT_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]      BLANK_END = CNT_W'(BLANK_CYCLES);
    localparam logic [7:0]            SEG_OFF   = {8{SEG_ACT_LOW}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF   = {NUM_DIGITS{DIG_ACT_LOW}};

    typedef enum logic {
        PH_BLANK,
        PH_DRIVE
    } phase_t;

    // A slot begins in DRIVE when there is no blanking guard.
    localparam phase_t PH_RESET = (BLANK_CYCLES != 0) ? PH_BLANK : PH_DRIVE;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    phase_t                  phase_q, phase_d;
    logic [NUM_DIGITS*4-1:0] pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic [NUM_DIGITS-1:0]   pend_mask_q, pend_mask_d;
    logic                    pend_valid_q, pend_valid_d;
    logic [NUM_DIGITS*4-1:0] act_data_q, act_data_d;
    logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
    logic [NUM_DIGITS-1:0]   act_mask_q, act_mask_d;
    logic [7:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   dig_q, dig_d;
    logic                    frame_done_q, frame_done_d;

    logic                    frame_end;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_en;
    logic [NUM_DIGITS-1:0]   cur_onehot;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            phase_q      <= PH_RESET;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_mask_q  <= '0;
            pend_valid_q <= 1'b0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_mask_q   <= '0;
            seg_q        <= SEG_OFF;
            dig_q        <= DIG_OFF;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            phase_q      <= phase_d;
            pend_data_q  <= pend_data_d;
            pend_dp_q    <= pend_dp_d;
            pend_mask_q  <= pend_mask_d;
            pend_valid_q <= pend_valid_d;
            act_data_q   <= act_data_d;
            act_dp_q     <= act_dp_d;
            act_mask_q   <= act_mask_d;
            seg_q        <= seg_d;
            dig_q        <= dig_d;
            frame_done_q <= frame_done_d;
        end
    end

    // Output registers are loaded from the next-state counters and buffers,
    // so the pins line up with cnt/idx in the same cycle with no lag.
    always_comb begin
        cnt_d        = cnt_q + 1'b1;
        idx_d        = idx_q;
        phase_d      = phase_q;
        pend_data_d  = pend_data_q;
        pend_dp_d    = pend_dp_q;
        pend_mask_d  = pend_mask_q;
        pend_valid_d = pend_valid_q;
        act_data_d   = act_data_q;
        act_dp_d     = act_dp_q;
        act_mask_d   = act_mask_q;
        cur_nib      = 4'h0;
        cur_dp       = 1'b0;
        cur_en       = 1'b0;
        cur_onehot   = '0;

        frame_end = (cnt_q == CNT_LAST) && (idx_q == IDX_LAST);

        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        // A load on the frame-end cycle goes straight to the active buffer.
        if (i_load) begin
            if (frame_end) begin
                act_data_d   = i_data;
                act_dp_d     = i_dp;
                act_mask_d   = i_en_mask;
                pend_valid_d = 1'b0;
            end else begin
                pend_data_d  = i_data;
                pend_dp_d    = i_dp;
                pend_mask_d  = i_en_mask;
                pend_valid_d = 1'b1;
            end
        end else if (frame_end && pend_valid_q) begin
            act_data_d   = pend_data_q;
            act_dp_d     = pend_dp_q;
            act_mask_d   = pend_mask_q;
            pend_valid_d = 1'b0;
        end

        case (phase_q)
            PH_BLANK: if (cnt_d == BLANK_END) phase_d = PH_DRIVE;
            PH_DRIVE: if ((cnt_d == '0) && (BLANK_CYCLES != 0)) phase_d = PH_BLANK;
            default:  phase_d = PH_RESET;
        endcase

        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            if (idx_d == IDX_W'(k)) begin
                cur_nib       = act_data_d[4*k +: 4];
                cur_dp        = act_dp_d[k];
                cur_en        = act_mask_d[k];
                cur_onehot[k] = 1'b1;
            end
        end

        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (phase_d == PH_DRIVE) begin
            seg_d = {cur_dp, hex_to_seg(cur_nib)} ^ SEG_OFF;
            if (cur_en) begin
                dig_d = cur_onehot ^ DIG_OFF;
            end
        end

        frame_done_d = (cnt_d == CNT_LAST) && (idx_d == IDX_LAST);
    end

    assign o_seg        = seg_q;
    assign o_dig_sel    = dig_q;
    assign o_frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_driver.sv
module tb_led_scan_driver;

    localparam int ND    = 4;
    localparam int DIV   = 8;
    localparam int BLANK = 2;

    typedef struct {
        logic [7:0] seg;
        logic [3:0] dig;
        logic       fd;
    } exp_t;

    bit          clk;
    logic        rst_n;
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  mask;
    logic        load;
    logic [7:0]  o_seg;
    logic [3:0]  o_dig_sel;
    logic        o_frame_done;

    int n_checks = 0;
    int n_pass   = 0;

    exp_t sb[$];

    // Reference model state
    int          m_cnt, m_idx;
    logic [15:0] m_pdata, m_adata;
    logic [3:0]  m_pdp, m_adp, m_pmask, m_amask;
    bit          m_pv;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    led_scan_driver #(
        .NUM_DIGITS  (ND),
        .CLK_DIV     (DIV),
        .BLANK_CYCLES(BLANK),
        .SEG_ACT_LOW (1'b1),
        .DIG_ACT_LOW (1'b1)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_data      (data),
        .i_dp        (dp),
        .i_en_mask   (mask),
        .i_load      (load),
        .o_seg       (o_seg),
        .o_dig_sel   (o_dig_sel),
        .o_frame_done(o_frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    task automatic model_step();
        exp_t e;
        bit   fe;
        int   nib;
        if (!rst_n) begin
            m_cnt = 0; m_idx = 0; m_pv = 0;
            m_pdata = '0; m_pdp = '0; m_pmask = '0;
            m_adata = '0; m_adp = '0; m_amask = '0;
            e.seg = 8'hFF; e.dig = 4'hF; e.fd = 1'b0;
        end else begin
            fe = (m_cnt == DIV - 1) && (m_idx == ND - 1);
            if (load && fe) begin
                m_adata = data; m_adp = dp; m_amask = mask; m_pv = 0;
            end else if (load) begin
                m_pdata = data; m_pdp = dp; m_pmask = mask; m_pv = 1;
            end else if (fe && m_pv) begin
                m_adata = m_pdata; m_adp = m_pdp; m_amask = m_pmask; m_pv = 0;
            end
            m_cnt++;
            if (m_cnt == DIV) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % ND;
            end
            if (m_cnt >= BLANK) begin
                nib   = int'((m_adata >> (4 * m_idx)) & 16'hF);
                e.seg = ~{m_adp[m_idx], seg_tbl[nib]};
                e.dig = m_amask[m_idx] ? ~(4'b0001 << m_idx) : 4'hF;
            end else begin
                e.seg = 8'hFF;
                e.dig = 4'hF;
            end
            e.fd = (m_cnt == DIV - 1) && (m_idx == ND - 1);
        end
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk_val("sb_seg", {24'b0, o_seg}, {24'b0, e.seg});
            chk_val("sb_dig", {28'b0, o_dig_sel}, {28'b0, e.dig});
            chk_val("sb_fd", {31'b0, o_frame_done}, {31'b0, e.fd});
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_state(input int c, input int i);
        int n = 0;
        while (!(m_cnt == c && m_idx == i) && n < 100) begin
            step(1);
            n++;
        end
        if (n >= 100) chk_val("wait_timeout", 0, 1);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] m);
        data = d; dp = p; mask = m; load = 1'b1;
        step(1);
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] nib;
        logic       pdp;
        int         fd_cnt;
        rst_n = 1'b0; data = '0; dp = '0; mask = '0; load = 1'b0;

        // Reset
        step(3);
        chk_val("rst_seg", {24'b0, o_seg}, 32'hFF);
        chk_val("rst_dig", {28'b0, o_dig_sel}, 32'hF);
        chk_val("rst_fd", {31'b0, o_frame_done}, 32'h0);
        rst_n = 1'b1;

        // Basic frame
        do_load(16'h3210, 4'h0, 4'hF);
        wait_state(0, 0);
        chk_val("s0_blank_dig", {28'b0, o_dig_sel}, 32'hF);
        step(2);
        chk_val("s0_dig", {28'b0, o_dig_sel}, 32'hE);
        chk_val("s0_seg", {24'b0, o_seg}, 32'hC0);
        step(8);
        chk_val("s1_dig", {28'b0, o_dig_sel}, 32'hD);
        chk_val("s1_seg", {24'b0, o_seg}, 32'hF9);
        step(8);
        chk_val("s2_dig", {28'b0, o_dig_sel}, 32'hB);
        chk_val("s2_seg", {24'b0, o_seg}, 32'hA4);
        step(8);
        chk_val("s3_dig", {28'b0, o_dig_sel}, 32'h7);
        chk_val("s3_seg", {24'b0, o_seg}, 32'hB0);

        // Sweep every nibble with and without the decimal point
        for (int v = 0; v < 32; v++) begin
            nib = 4'(v);
            pdp = (v >= 16);
            do_load({4{nib}}, {4{pdp}}, 4'hF);
            wait_state(0, 0);
            step(2);
            chk_val("sweep_seg", {24'b0, o_seg}, {24'b0, ~{pdp, seg_tbl[nib]}});
            step(29);
        end

        // Masked digits keep their slot time but stay dark
        do_load(16'h3210, 4'h0, 4'b1010);
        wait_state(0, 0);
        fd_cnt = 0;
        for (int i = 0; i < 64; i++) begin
            if (i == 4)  chk_val("mask_s0_dig", {28'b0, o_dig_sel}, 32'hF);
            if (i == 12) chk_val("mask_s1_dig", {28'b0, o_dig_sel}, 32'hD);
            if (i == 20) chk_val("mask_s2_dig", {28'b0, o_dig_sel}, 32'hF);
            if (i == 28) chk_val("mask_s3_dig", {28'b0, o_dig_sel}, 32'h7);
            if (o_frame_done) fd_cnt++;
            step(1);
        end
        chk_val("mask_fd_count", fd_cnt, 2);

        // No tearing, then frame-end bypass
        do_load(16'h3210, 4'h0, 4'hF);
        wait_state(0, 0);
        wait_state(1, 1);
        do_load(16'hFFFF, 4'h0, 4'hF);
        data = 16'h0000;
        wait_state(2, 3);
        chk_val("notear_s3", {24'b0, o_seg}, 32'hB0);
        wait_state(2, 0);
        chk_val("newframe_s0", {24'b0, o_seg}, 32'h8E);
        wait_state(7, 3);
        do_load(16'h4444, 4'h0, 4'hF);
        step(2);
        chk_val("bypass_s0", {24'b0, o_seg}, 32'h99);
        wait_state(2, 0);
        chk_val("bypass_hold", {24'b0, o_seg}, 32'h99);

        // Reset mid-scan
        do_load(16'h3210, 4'h0, 4'hF);
        wait_state(0, 0);
        wait_state(5, 2);
        rst_n = 1'b0;
        step(1);
        chk_val("midrst_seg", {24'b0, o_seg}, 32'hFF);
        chk_val("midrst_dig", {28'b0, o_dig_sel}, 32'hF);
        chk_val("midrst_fd", {31'b0, o_frame_done}, 32'h0);
        rst_n = 1'b1;
        step(3);
        chk_val("dark_dig", {28'b0, o_dig_sel}, 32'hF);
        chk_val("dark_seg", {24'b0, o_seg}, 32'hC0);
        step(40);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
